qq_pulse_seq: RTL
=================

Name: qq_pulse_seq

Overview:
- Timing sequencer for the H-bridge switch state machine.
- Generates the thermometer-coded step vector i_step[3:0] consumed by that machine, with programmable phase durations. Phases: positive drive, full drive, positive drive, off.
- Repeats the burst a programmable number of times, with a rest interval between bursts.
- Consumes the switch machine's active-low stateover to confirm each burst has ended before releasing the bridge.

Parameters:
- CNT_W, 16, width of phase and rest duration counters.
- NCYC_W, 8, width of burst-repeat count.
- WDOG_CYC, 1023, END-state watchdog limit in clk_sys cycles (used only with QQ_SEQ_WDOG_EN).

Ports:
- clk_sys  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sequence; ignored while busy=1.
- abort  input  1  synchronous abort; returns to IDLE on the next edge.
- t1  input  CNT_W  PH1 duration in cycles (0 treated as 1).
- t2  input  CNT_W  PH2 duration (0 treated as 1).
- t3  input  CNT_W  PH3 duration (0 treated as 1).
- t_rest  input  CNT_W  REST duration between bursts (0 treated as 1).
- n_cyc  input  NCYC_W  number of bursts (0 treated as 1).
- stateover  input  1  from the switch machine; low means it has reached its terminal state.
- i_step  output  4  step vector to the switch machine.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- cyc_cnt  output  NCYC_W  number of bursts completed in the current or last sequence.
- err  output  1  sticky watchdog error; cleared by the next accepted start.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, i_step=4'b0000, busy=0, done=0, cyc_cnt=0, err=0, internal counters 0.
- Registers and default outputs:
  - All outputs are registered.
  - done defaults to 0 each cycle.
- Start and latching:
  - start is accepted only in IDLE.
  - On an accepted start, t1, t2, t3, t_rest and n_cyc are latched; later input changes have no effect.
  - Zero durations and a zero n_cyc are replaced by 1 at latch time.
- States and i_step encoding:
  - IDLE: 0000
  - PH1: 0001
  - PH2: 0011
  - PH3: 0111
  - END: 1111
  - REST: 0000
- Transitions:
  - IDLE -> PH1 on start; cyc_cnt<=0; err<=0.
  - PH1/PH2/PH3 hold for exactly the latched duration, then advance: PH1 -> PH2 -> PH3 -> END. The down-counter is loaded on entry and the state advances when it reaches 1.
  - END holds i_step=1111 until stateover is sampled low. On that cycle cyc_cnt increments.
  - From END: if cyc_cnt+1 < n_cyc, go to REST; otherwise go to IDLE with done=1 and busy=0 on the same edge.
  - REST holds for t_rest cycles, then goes to PH1. The switch machine sees i_step[0]=0, which resets it.
- Latency:
  - With start high at edge k, i_step=0001 from edge k+1 for t1 cycles.
  - It is 0011 for the next t2 cycles and 0111 for the next t3 cycles.
  - It is 1111 from edge k+1+t1+t2+t3.
- Simultaneous events and boundaries:
  - abort has priority over all transitions: next edge gives IDLE, i_step=0000, busy=0, done=0. cyc_cnt holds its value; err is unchanged.
  - start coincident with abort in IDLE: abort wins, start is dropped.
  - stateover already low on END entry: END lasts exactly one cycle.
  - cyc_cnt is compared at full NCYC_W width; n_cyc=2^NCYC_W-1 runs that many bursts without wrap.
  - stateover is ignored outside END.

Optional Feature:
- Macro QQ_SEQ_WDOG_EN.
- Defined:
  - A watchdog counter runs while in END.
  - If stateover is not sampled low within WDOG_CYC cycles, the block sets err=1, forces i_step=0000 and returns to IDLE without a done pulse. cyc_cnt is not incremented.
- Undefined:
  - No watchdog; END waits indefinitely.
  - err is tied to 0.

Test Plan:
- Single burst: t1=3, t2=5, t3=3, n_cyc=1, stateover low 2 cycles after END entry.
  - i_step is 0001 for 3 cycles, 0011 for 5, 0111 for 3, then 1111 for 3 cycles.
  - Then 0000, with a done pulse and cyc_cnt=1.
- Zero durations: t1=t2=t3=0, n_cyc=0, stateover tied low -> each phase lasts 1 cycle, END lasts 1 cycle, done on the 5th edge after start, cyc_cnt=1.
- Repeat: n_cyc=3, t_rest=4 -> three bursts, each separated by exactly 4 cycles of i_step=0000; done once after the third; cyc_cnt=3.
- Abort during PH2 of burst 2 of 3 -> next edge: i_step=0000, busy=0, no done pulse, cyc_cnt=1. A start during an active sequence is ignored.
- Async reset asserted mid-END -> i_step=0000 and busy=0 immediately, without waiting for a clock edge; a start after release begins a fresh sequence.
- With QQ_SEQ_WDOG_EN and WDOG_CYC=16, stateover held high -> 16 cycles after END entry: err=1, i_step=0000, no done pulse; the next accepted start clears err.

Source files
------------

// File: rtl/qq_pulse_seq.sv
// Pulse timing sequencer for the H-bridge switch machine: thermometer step vector, burst repeat, rest gap.
// Optional END-state watchdog enabled by defining QQ_SEQ_WDOG_EN.
module qq_pulse_seq #(
    parameter int CNT_W    = 16,
    parameter int NCYC_W   = 8,
    parameter int WDOG_CYC = 1023
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  t1,
    input  logic [CNT_W-1:0]  t2,
    input  logic [CNT_W-1:0]  t3,
    input  logic [CNT_W-1:0]  t_rest,
    input  logic [NCYC_W-1:0] n_cyc,
    input  logic              stateover,
    output logic [3:0]        i_step,
    output logic              busy,
    output logic              done,
    output logic [NCYC_W-1:0] cyc_cnt,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_PH1, S_PH2, S_PH3, S_END, S_REST
    } state_e;

    state_e            state_q;
    logic [3:0]        step_q;
    logic              busy_q, done_q, err_q;
    logic [NCYC_W-1:0] cyc_q, ncyc_q;
    logic [CNT_W-1:0]  cnt_q, t1_q, t2_q, t3_q, trest_q;

    // Zero durations and counts are promoted to 1 before latching.
    logic [CNT_W-1:0]  t1_d, t2_d, t3_d, trest_d;
    logic [NCYC_W-1:0] ncyc_d;
    logic [NCYC_W:0]   cyc_inc_d;

    assign t1_d      = (t1     == '0) ? CNT_W'(1)  : t1;
    assign t2_d      = (t2     == '0) ? CNT_W'(1)  : t2;
    assign t3_d      = (t3     == '0) ? CNT_W'(1)  : t3;
    assign trest_d   = (t_rest == '0) ? CNT_W'(1)  : t_rest;
    assign ncyc_d    = (n_cyc  == '0) ? NCYC_W'(1) : n_cyc;
    assign cyc_inc_d = {1'b0, cyc_q} + (NCYC_W+1)'(1);

`ifdef QQ_SEQ_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    logic [WD_W-1:0] wdog_q;
`endif

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            ncyc_q  <= '0;
            cnt_q   <= '0;
            t1_q    <= '0;
            t2_q    <= '0;
            t3_q    <= '0;
            trest_q <= '0;
`ifdef QQ_SEQ_WDOG_EN
            wdog_q  <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (abort) begin
                state_q <= S_IDLE;
                step_q  <= 4'b0000;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: if (start) begin
                        t1_q    <= t1_d;
                        t2_q    <= t2_d;
                        t3_q    <= t3_d;
                        trest_q <= trest_d;
                        ncyc_q  <= ncyc_d;
                        cnt_q   <= t1_d;
                        cyc_q   <= '0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        step_q  <= 4'b0001;
                        state_q <= S_PH1;
                    end
                    S_PH1: if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= t2_q;
                        step_q  <= 4'b0011;
                        state_q <= S_PH2;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    S_PH2: if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= t3_q;
                        step_q  <= 4'b0111;
                        state_q <= S_PH3;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    S_PH3: if (cnt_q == CNT_W'(1)) begin
                        step_q  <= 4'b1111;
                        state_q <= S_END;
`ifdef QQ_SEQ_WDOG_EN
                        wdog_q  <= '0;
`endif
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    S_END: if (!stateover) begin
                        cyc_q <= cyc_inc_d[NCYC_W-1:0];
                        // Widened compare so n_cyc = all-ones never wraps.
                        if (cyc_inc_d < {1'b0, ncyc_q}) begin
                            cnt_q   <= trest_q;
                            step_q  <= 4'b0000;
                            state_q <= S_REST;
                        end else begin
                            step_q  <= 4'b0000;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
`ifdef QQ_SEQ_WDOG_EN
                    else if (wdog_q == WD_W'(WDOG_CYC - 1)) begin
                        err_q   <= 1'b1;
                        step_q  <= 4'b0000;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
`endif
                    S_REST: if (cnt_q == CNT_W'(1)) begin
                        cnt_q   <= t1_q;
                        step_q  <= 4'b0001;
                        state_q <= S_PH1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    default: begin
                        step_q  <= 4'b0000;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign i_step  = step_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign cyc_cnt = cyc_q;
`ifdef QQ_SEQ_WDOG_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule
